axis_loopback_buf: RTL and testbench
====================================

Name: axis_loopback_buf

Overview:
- Parametrised, buffered successor to the wire-level MM2S->S2MM stream loopback between the read DMA stream output and the write DMA stream input.
- Adds a DEPTH-entry FIFO, per-packet mode select (pass, byte-reverse, drop) and packet/beat statistics readable by the DMA controller register file.
- Decouples s2mm back-pressure from mm2s, so no combinational ready path crosses the block.

Parameters:
- DATA_WIDTH, 128, tdata width in bits; multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 8, tuser width; carried through unchanged.
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- s_axis_tdata  in  DATA_WIDTH  input beat data, from mm2s
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables
- s_axis_tuser  in  USER_WIDTH  input user
- s_axis_tlast  in  1  end of packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DATA_WIDTH  output data, to s2mm
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables
- m_axis_tuser  out  USER_WIDTH  output user
- m_axis_tlast  out  1  output end of packet
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- mode  in  2  0=pass, 1=byte-reverse, 2=drop, 3=reserved (treated as pass)
- clr_stats  in  1  synchronous clear of all counters
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- pkt_in_cnt  out  CNT_WIDTH  packets accepted on s_axis
- pkt_out_cnt  out  CNT_WIDTH  packets sent on m_axis
- pkt_drop_cnt  out  CNT_WIDTH  packets discarded in drop mode
- beat_out_cnt  out  CNT_WIDTH  beats sent on m_axis

Behaviour:
- Reset (rstn low, async):
  - FIFO empty; level=0; s_axis_tready=0 during reset, 1 from the first clk edge after release.
  - m_axis_tvalid=0; m_axis_tdata/tkeep/tuser/tlast=0.
  - All counters 0; in_pkt=0; latched mode=pass.
  - Reset mid-packet discards everything; no partial packet survives.
- Handshake:
  - A beat transfers when valid&&ready at a rising clk.
  - s_axis_tready = (level < DEPTH), registered; it does not depend on m_axis_tready.
  - When full, a same-cycle pop does not allow a push; the next cycle's tready rises.
  - m_axis_tvalid, once high, holds with stable data until m_axis_tready.
- Latency: a beat accepted at edge N is visible on m_axis at edge N+1 when the FIFO was empty (first-word-fall-through output register). Throughput is 1 beat/cycle when unblocked.
- Mode latch:
  - mode is sampled on the first accepted beat of each packet (in_pkt=0) and held until that packet's tlast beat is accepted.
  - mode changes mid-packet take effect on the next packet.
- Pass: beat stored unchanged.
- Byte-reverse:
  - Byte lane i of tdata moves to lane KEEP_WIDTH-1-i; tkeep bit i moves to KEEP_WIDTH-1-i.
  - tuser and tlast are unchanged.
  - Applied on write, before storage.
- Drop:
  - Beats are accepted (tready follows the FIFO rule) but not written.
  - pkt_drop_cnt increments on the accepted tlast beat.
- in_pkt: set on an accepted beat with tlast=0, cleared on an accepted beat with tlast=1. A single-beat packet leaves in_pkt=0.
- Counters:
  - pkt_in_cnt increments on every accepted tlast beat, including dropped packets.
  - pkt_out_cnt increments on m_axis transfers with tlast=1.
  - beat_out_cnt increments on every m_axis transfer.
  - Counters wrap modulo 2^CNT_WIDTH.
  - clr_stats has priority over a same-cycle increment; the counter reads 0 next cycle.
- level: push only gives +1, pop only gives -1, push and pop together leave it unchanged. Range 0..DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: AXIS_LB_STORE_FWD_EN.
- Defined (store-and-forward):
  - m_axis_tvalid is gated until at least one complete packet (a stored tlast) is in the FIFO.
  - A stored-packet counter increments on a tlast push and decrements on a tlast pop.
  - If level==DEPTH with no stored tlast, the gate opens to avoid deadlock and stays open until the next tlast pops.
- Undefined: cut-through; output is valid as soon as any beat is stored.

Decomposition:
- Package axis_lb_pkg holds:
  - mode localparams MODE_PASS=2'd0, MODE_BREV=2'd1, MODE_DROP=2'd2.
  - a byte-reverse function parametrised by KEEP_WIDTH.
- Sub-module axis_lb_fifo_mem: simple dual-port DEPTH x (DATA_WIDTH+KEEP_WIDTH+USER_WIDTH+1) register array, write port plus async read port.
- Pointers, level and counters stay in the top of the block.

Test Plan:
- Pass, 4-beat packet, tdata=0x0..03 incrementing, tkeep=all ones, m_axis_tready=1 -> identical beats at 1-cycle latency; pkt_in_cnt=1, pkt_out_cnt=1, beat_out_cnt=4.
- Byte-reverse, tdata=0x000102...0F, tkeep=0x00FF -> tdata=0x0F0E...00, tkeep=0xFF00; tuser unchanged.
- Drop, three 2-beat packets -> no m_axis_tvalid; pkt_drop_cnt=3, pkt_in_cnt=3, level=0.
- m_axis_tready=0 while pushing 20 beats with DEPTH=16 -> s_axis_tready=0 once level=16; after tready=1 all 20 beats arrive in order.
- mode switches pass->brev on beat 2 of a 3-beat packet -> whole packet passes unchanged; the next packet is reversed.
- AXIS_LB_STORE_FWD_EN defined, 3-beat packet with a 5-cycle gap before tlast -> m_axis_tvalid rises only after tlast is stored; 20-beat packet with no tlast until beat 20 -> gate opens at level=16.

Source files
------------

// File: rtl/axis_lb_pkg.sv
// Shared definitions for axis_loopback_buf: per-packet mode codes and byte-reverse helpers.
package axis_lb_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_BREV = 2'd1;
    localparam logic [1:0] MODE_DROP = 2'd2;

    // Widest lane count the reverse helpers support; callers pass their real KEEP_WIDTH.
    localparam int unsigned BREV_MAX_BYTES = 128;

    function automatic logic [BREV_MAX_BYTES*8-1:0] brev_bytes(
        input logic [BREV_MAX_BYTES*8-1:0] d,
        input int unsigned                 kw
    );
        logic [BREV_MAX_BYTES*8-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BREV_MAX_BYTES; i++) begin
            if (i < kw) r[8*(kw-1-i) +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [BREV_MAX_BYTES-1:0] brev_bits(
        input logic [BREV_MAX_BYTES-1:0] k,
        input int unsigned               kw
    );
        logic [BREV_MAX_BYTES-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BREV_MAX_BYTES; i++) begin
            if (i < kw) r[kw-1-i] = k[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_lb_fifo_mem.sv
// Simple dual-port register array: synchronous write port, asynchronous read port.
module axis_lb_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/axis_loopback_buf.sv
// Buffered MM2S->S2MM loopback with per-packet pass/byte-reverse/drop and statistics.
// Define AXIS_LB_STORE_FWD_EN to hold m_axis until a complete packet is stored.
module axis_loopback_buf
    import axis_lb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic [USER_WIDTH-1:0]    m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    input  logic [1:0]               mode,
    input  logic                     clr_stats,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_WIDTH-1:0]     pkt_in_cnt,
    output logic [CNT_WIDTH-1:0]     pkt_out_cnt,
    output logic [CNT_WIDTH-1:0]     pkt_drop_cnt,
    output logic [CNT_WIDTH-1:0]     beat_out_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;
    localparam int unsigned BW = BREV_MAX_BYTES * 8;

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level_next;
    logic                  in_pkt;
    logic [1:0]            lat_mode;
    logic [1:0]            eff_mode;
    logic                  s_xfer;
    logic                  m_xfer;
    logic                  push;
    logic                  pop;
    logic                  gate_ok;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [KEEP_WIDTH-1:0] wr_keep;
    logic [EW-1:0]         wr_word;
    logic [EW-1:0]         rd_word;

    // The output register refills from the array whenever it is empty or being drained.
    always_comb begin
        eff_mode   = in_pkt ? lat_mode : mode;
        s_xfer     = s_axis_tvalid && s_axis_tready;
        m_xfer     = m_axis_tvalid && m_axis_tready;
        push       = s_xfer && (eff_mode != MODE_DROP);
        pop        = (level != '0) && (!m_axis_tvalid || m_axis_tready) && gate_ok;
        wr_data    = s_axis_tdata;
        wr_keep    = s_axis_tkeep;
        if (eff_mode == MODE_BREV) begin
            wr_data = DATA_WIDTH'(brev_bytes(BW'(s_axis_tdata), KEEP_WIDTH));
            wr_keep = KEEP_WIDTH'(brev_bits(BREV_MAX_BYTES'(s_axis_tkeep), KEEP_WIDTH));
        end
        level_next = level;
        if (push && !pop)      level_next = level + LW'(1);
        else if (pop && !push) level_next = level - LW'(1);
        wr_word    = {wr_data, wr_keep, s_axis_tuser, s_axis_tlast};
    end

    axis_lb_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (push),
        .waddr   (wr_ptr),
        .wdata   (wr_word),
        .raddr   (rd_ptr),
        .rdata_c (rd_word)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            s_axis_tready <= 1'b0;
            in_pkt        <= 1'b0;
            lat_mode      <= MODE_PASS;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            s_axis_tready <= (level_next < LW'(DEPTH));
            level         <= level_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (s_xfer) begin
                if (!in_pkt) lat_mode <= mode;
                in_pkt <= !s_axis_tlast;
            end
            if (pop) begin
                m_axis_tvalid <= 1'b1;
                {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} <= rd_word;
            end else if (m_xfer) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    // Statistics; a clear wins over any increment in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_in_cnt   <= '0;
            pkt_out_cnt  <= '0;
            pkt_drop_cnt <= '0;
            beat_out_cnt <= '0;
        end else if (clr_stats) begin
            pkt_in_cnt   <= '0;
            pkt_out_cnt  <= '0;
            pkt_drop_cnt <= '0;
            beat_out_cnt <= '0;
        end else begin
            if (s_xfer && s_axis_tlast) pkt_in_cnt <= pkt_in_cnt + CNT_WIDTH'(1);
            if (s_xfer && s_axis_tlast && (eff_mode == MODE_DROP))
                pkt_drop_cnt <= pkt_drop_cnt + CNT_WIDTH'(1);
            if (m_xfer) beat_out_cnt <= beat_out_cnt + CNT_WIDTH'(1);
            if (m_xfer && m_axis_tlast) pkt_out_cnt <= pkt_out_cnt + CNT_WIDTH'(1);
        end
    end

`ifdef AXIS_LB_STORE_FWD_EN
    logic [LW-1:0] stored_pkts;
    logic          gate_open;

    always_comb gate_ok = (stored_pkts != '0) || gate_open;

    // A full array with no packet end would never drain, so force the gate open until a tlast leaves.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stored_pkts <= '0;
            gate_open   <= 1'b0;
        end else begin
            if ((push && s_axis_tlast) && !(pop && rd_word[0]))
                stored_pkts <= stored_pkts + LW'(1);
            else if (!(push && s_axis_tlast) && (pop && rd_word[0]))
                stored_pkts <= stored_pkts - LW'(1);
            if (pop && rd_word[0])
                gate_open <= 1'b0;
            else if ((level == LW'(DEPTH)) && (stored_pkts == '0))
                gate_open <= 1'b1;
        end
    end
`else
    always_comb gate_ok = 1'b1;
`endif

endmodule

// File: tb/tb_axis_loopback_buf.sv
// Self-checking bench for axis_loopback_buf: vector table, hand sequences and a random run
// against a packet-level queue model.
module tb_axis_loopback_buf;

    localparam int DW    = 128;
    localparam int KW    = 16;
    localparam int UW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 32;
    localparam int NV    = 6;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        logic [1:0]    mode;
        beat_t         in;
        bit            exp_out;
        logic [DW-1:0] exp_data;
        logic [KW-1:0] exp_keep;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [1:0]    mode;
    logic          clr_stats;
    logic [$clog2(DEPTH):0] level;
    logic [CW-1:0] pkt_in_cnt;
    logic [CW-1:0] pkt_out_cnt;
    logic [CW-1:0] pkt_drop_cnt;
    logic [CW-1:0] beat_out_cnt;

    always #5 clk = ~clk;

    axis_loopback_buf #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .USER_WIDTH (UW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .mode          (mode),
        .clr_stats     (clr_stats),
        .level         (level),
        .pkt_in_cnt    (pkt_in_cnt),
        .pkt_out_cnt   (pkt_out_cnt),
        .pkt_drop_cnt  (pkt_drop_cnt),
        .beat_out_cnt  (beat_out_cnt)
    );

    int          errors = 0;
    int          checks = 0;
    beat_t       exp_q[$];
    bit          m_in_pkt;
    logic [1:0]  m_lat;
    int unsigned e_in, e_out, e_drop, e_beat;
    int          out_beats = 0;
    beat_t       last_out;
    bit          prev_v, prev_r;
    beat_t       prev_b;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                 input logic [UW-1:0] u, input logic l);
        beat_t b;
        b.data = d; b.keep = k; b.user = u; b.last = l;
        return b;
    endfunction

    function automatic beat_t brev(input beat_t b);
        beat_t r;
        r = b;
        for (int i = 0; i < KW; i++) begin
            r.data[8*(KW-1-i) +: 8] = b.data[8*i +: 8];
            r.keep[KW-1-i]          = b.keep[i];
        end
        return r;
    endfunction

    // Packet-level model: the mode a packet gets is whatever was presented with its first beat.
    task automatic model_push(input beat_t b, input logic [1:0] md);
        logic [1:0] eff;
        eff = m_in_pkt ? m_lat : md;
        if (!m_in_pkt) m_lat = md;
        m_in_pkt = !b.last;
        if (b.last) begin
            e_in++;
            if (eff == 2'd2) e_drop++;
        end
        if (eff == 2'd1)      exp_q.push_back(brev(b));
        else if (eff != 2'd2) exp_q.push_back(b);
    endtask

    task automatic model_pop(input beat_t o);
        beat_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got %0h expected no beat", o);
        end else begin
            e = exp_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL out_beat: got %0h expected %0h", o, e);
            end
        end
        e_beat++;
        if (o.last) e_out++;
        out_beats++;
        last_out = o;
    endtask

    task automatic tick(output bit acc);
        beat_t cur;
        @(negedge clk);
        cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
        if (prev_v && !prev_r) begin
            checks++;
            if (!m_axis_tvalid || cur !== prev_b) begin
                errors++;
                $display("FAIL hold_stable: got v=%0b %0h expected v=1 %0h", m_axis_tvalid, cur, prev_b);
            end
        end
        prev_v = m_axis_tvalid;
        prev_r = m_axis_tready;
        prev_b = cur;
        acc = s_axis_tvalid && s_axis_tready;
        if (acc) model_push({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast}, mode);
        if (m_axis_tvalid && m_axis_tready) model_pop(cur);
        if (clr_stats) begin
            e_in = 0; e_out = 0; e_drop = 0; e_beat = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input beat_t b, input logic [1:0] md);
        bit acc;
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = b;
        mode = md;
        do begin
            tick(acc);
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 300) begin
            tick(acc);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || m_axis_tvalid) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_pkt_in"},   DW'(pkt_in_cnt),   DW'(e_in));
        chk({tag, "_pkt_out"},  DW'(pkt_out_cnt),  DW'(e_out));
        chk({tag, "_pkt_drop"}, DW'(pkt_drop_cnt), DW'(e_drop));
        chk({tag, "_beat_out"}, DW'(beat_out_cnt), DW'(e_beat));
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        clr_stats     = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        exp_q.delete();
        m_in_pkt = 1'b0; m_lat = 2'd0;
        e_in = 0; e_out = 0; e_drop = 0; e_beat = 0;
        prev_v = 1'b0;
        chk("rst_s_ready", DW'(s_axis_tready), '0);
        chk("rst_m_valid", DW'(m_axis_tvalid), '0);
        chk("rst_m_data",  m_axis_tdata, '0);
        chk("rst_level",   DW'(level), '0);
        check_counts("rst");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", DW'(s_axis_tready), DW'(1));
    endtask

    task automatic pulse_clr();
        bit acc;
        clr_stats = 1'b1;
        tick(acc);
        clr_stats = 1'b0;
        chk("clr_pkt_in", DW'(pkt_in_cnt), '0);
    endtask

    vec_t  vt[NV];
    beat_t b;
    bit    acc, bad, saw_full;
    int    pre, k;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{2'd0, mk(128'h000102030405060708090a0b0c0d0e0f, 16'hffff, 8'h5a, 1'b1),
                  1'b1, 128'h000102030405060708090a0b0c0d0e0f, 16'hffff};
        vt[1] = '{2'd1, mk(128'h000102030405060708090a0b0c0d0e0f, 16'h00ff, 8'hc3, 1'b1),
                  1'b1, 128'h0f0e0d0c0b0a09080706050403020100, 16'hff00};
        vt[2] = '{2'd1, mk(128'h11223344_00000000_00000000_aabbccdd, 16'h8001, 8'h01, 1'b1),
                  1'b1, 128'hddccbbaa_00000000_00000000_44332211, 16'h8001};
        vt[3] = '{2'd3, mk(128'hcafef00d_12345678_9abcdef0_0badbeef, 16'h0003, 8'h77, 1'b1),
                  1'b1, 128'hcafef00d_12345678_9abcdef0_0badbeef, 16'h0003};
        vt[4] = '{2'd2, mk(128'h55, 16'hffff, 8'h10, 1'b1), 1'b0, '0, '0};
        vt[5] = '{2'd1, mk(128'hff, 16'h0001, 8'h20, 1'b1),
                  1'b1, 128'hff000000_00000000_00000000_00000000, 16'h8000};

        rstn = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
        s_axis_tlast = 1'b0; m_axis_tready = 1'b1; mode = 2'd0; clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        do_reset();

        // Single-beat latency: accepted at edge N, valid after edge N+1.
        s_axis_tvalid = 1'b1;
        {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = mk(128'h1234, 16'hffff, 8'h09, 1'b1);
        tick(acc);
        s_axis_tvalid = 1'b0;
        chk("lat_acc", DW'(acc), DW'(1));
        chk("lat_n_valid", DW'(m_axis_tvalid), '0);
        chk("lat_n_level", DW'(level), DW'(1));
        tick(acc);
        chk("lat_n1_valid", DW'(m_axis_tvalid), DW'(1));
        chk("lat_n1_data", m_axis_tdata, 128'h1234);
        drain();

        for (int i = 0; i < NV; i++) begin
            pre = out_beats;
            send_beat(vt[i].in, vt[i].mode);
            drain();
            if (vt[i].exp_out) begin
                chk($sformatf("vec%0d_count", i), DW'(out_beats), DW'(pre + 1));
                chk($sformatf("vec%0d_data", i), last_out.data, vt[i].exp_data);
                chk($sformatf("vec%0d_keep", i), DW'(last_out.keep), DW'(vt[i].exp_keep));
                chk($sformatf("vec%0d_user", i), DW'(last_out.user), DW'(vt[i].in.user));
                chk($sformatf("vec%0d_last", i), DW'(last_out.last), DW'(1));
            end else begin
                chk($sformatf("vec%0d_count", i), DW'(out_beats), DW'(pre));
            end
        end
        check_counts("table");

        // Four-beat pass packet from cleared counters.
        pulse_clr();
        for (int i = 0; i < 4; i++) send_beat(mk(DW'(i), 16'hffff, 8'h00, i == 3), 2'd0);
        drain();
        chk("pass4_pkt_in",  DW'(pkt_in_cnt),   DW'(1));
        chk("pass4_pkt_out", DW'(pkt_out_cnt),  DW'(1));
        chk("pass4_beats",   DW'(beat_out_cnt), DW'(4));

        // Clear wins over a same-cycle increment.
        clr_stats = 1'b1;
        send_beat(mk(128'h77, 16'hffff, 8'h00, 1'b1), 2'd0);
        clr_stats = 1'b0;
        chk("clr_prio_in", DW'(pkt_in_cnt), '0);
        drain();
        chk("clr_prio_out", DW'(pkt_out_cnt), DW'(1));

        // Drop mode: three 2-beat packets, nothing emitted.
        pulse_clr();
        pre = out_beats;
        for (int i = 0; i < 6; i++) send_beat(mk(DW'(i + 40), 16'hffff, 8'h00, i[0]), 2'd2);
        drain();
        chk("drop_no_out", DW'(out_beats), DW'(pre));
        chk("drop_cnt",    DW'(pkt_drop_cnt), DW'(3));
        chk("drop_in_cnt", DW'(pkt_in_cnt),   DW'(3));
        chk("drop_level",  DW'(level), '0);

        // Back-pressure: array plus output register absorb 17 beats, then tready falls.
        m_axis_tready = 1'b0;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            s_axis_tvalid = 1'b1;
            {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = mk(DW'(k + 256), 16'hffff, 8'h3c, 1'b1);
            mode = 2'd0;
            tick(acc);
            if (acc) k++;
            else break;
        end
        chk("bp_accepted", DW'(k), DW'(17));
        chk("bp_level",    DW'(level), DW'(16));
        chk("bp_s_ready",  DW'(s_axis_tready), '0);
        m_axis_tready = 1'b1;
        while (k < 20) begin
            send_beat(mk(DW'(k + 256), 16'hffff, 8'h3c, 1'b1), 2'd0);
            k++;
        end
        drain();

        // Mode change mid-packet only affects the following packet.
        send_beat(mk(128'ha0a1, 16'hffff, 8'h01, 1'b0), 2'd0);
        send_beat(mk(128'hb0b1, 16'hffff, 8'h02, 1'b0), 2'd1);
        send_beat(mk(128'hc0c1, 16'hffff, 8'h03, 1'b1), 2'd1);
        drain();
        chk("msw_pkt1_last", last_out.data, 128'hc0c1);
        send_beat(mk(128'h000102030405060708090a0b0c0d0e0f, 16'hffff, 8'h04, 1'b1), 2'd1);
        drain();
        chk("msw_pkt2_rev", last_out.data, 128'h0f0e0d0c0b0a09080706050403020100);

        // Reset mid-packet leaves no trace of the partial packet or its mode.
        send_beat(mk(128'hdead, 16'hffff, 8'h00, 1'b0), 2'd1);
        do_reset();
        pre = out_beats;
        send_beat(mk(128'h00ff, 16'h0001, 8'h00, 1'b1), 2'd0);
        drain();
        chk("postrst_count", DW'(out_beats), DW'(pre + 1));
        chk("postrst_data",  last_out.data, 128'h00ff);

`ifdef AXIS_LB_STORE_FWD_EN
        // Output held back until the packet end is stored.
        bad = 1'b0;
        send_beat(mk(128'h1, 16'hffff, 8'h00, 1'b0), 2'd0);
        send_beat(mk(128'h2, 16'hffff, 8'h00, 1'b0), 2'd0);
        for (int c = 0; c < 5; c++) begin
            tick(acc);
            if (m_axis_tvalid) bad = 1'b1;
        end
        chk("sf_gap_gated", DW'(bad), '0);
        send_beat(mk(128'h3, 16'hffff, 8'h00, 1'b1), 2'd0);
        tick(acc);
        chk("sf_open_after_last", DW'(m_axis_tvalid), DW'(1));
        drain();
        // A packet longer than the array opens the gate once full.
        bad = 1'b0; saw_full = 1'b0; pre = out_beats;
        for (int i = 0; i < 20; i++) begin
            send_beat(mk(DW'(i + 512), 16'hffff, 8'h00, i == 19), 2'd0);
            if (level == 16) saw_full = 1'b1;
            if (m_axis_tvalid && !saw_full) bad = 1'b1;
        end
        drain();
        chk("sf_full_seen",  DW'(saw_full), DW'(1));
        chk("sf_gate_early", DW'(bad), '0);
        chk("sf_long_count", DW'(out_beats), DW'(pre + 20));
`else
        // Cut-through: output valid before the packet end arrives.
        send_beat(mk(128'h1, 16'hffff, 8'h00, 1'b0), 2'd0);
        tick(acc);
        chk("ct_valid_early", DW'(m_axis_tvalid), DW'(1));
        send_beat(mk(128'h2, 16'hffff, 8'h00, 1'b1), 2'd0);
        drain();
`endif

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            s_axis_tvalid = ($urandom_range(3) != 0);
            s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
            s_axis_tkeep  = 16'($urandom);
            s_axis_tuser  = 8'($urandom);
            s_axis_tlast  = ($urandom_range(3) == 0);
            mode          = 2'($urandom);
            m_axis_tready = ($urandom_range(3) != 0);
            clr_stats     = ($urandom_range(60) == 0);
            tick(acc);
        end
        clr_stats = 1'b0;
        if (m_in_pkt) send_beat(mk(128'hfeed, 16'hffff, 8'h00, 1'b1), 2'd0);
        drain();
        check_counts("rand");
        chk("rand_level", DW'(level), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
